// File: rtl/clcd_bus_sequencer_if.sv
// Request handshake between the CLCD register block (master) and the
// LCD bus sequencer (slave).
interface clcd_bus_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (
    output req_valid,
    output req_rs,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rs,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/clcd_bus_sequencer.sv
// HD44780 8-bit bus sequencer: power-up init, then single command/data
// byte writes with RS/E/DB timing and execution waits.
// Optional macro CLCD_REQ_FIFO_EN adds a 4-entry request FIFO in front
// of the FSM; without it a single request is latched per transfer.
module clcd_bus_sequencer #(
  parameter int unsigned PWRUP_WAIT_CYC = 1500000,
  parameter int unsigned SETUP_CYC      = 10,
  parameter int unsigned E_PULSE_CYC    = 50,
  parameter int unsigned CMD_WAIT_CYC   = 4000,
  parameter int unsigned CLR_WAIT_CYC   = 164000
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  clcd_bus_sequencer_if.slave   req,
  output logic                  init_done,
  output logic                  busy,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_e,
  output logic [7:0]            lcd_db
);

  localparam int unsigned MAX_0 = (PWRUP_WAIT_CYC > SETUP_CYC) ? PWRUP_WAIT_CYC : SETUP_CYC;
  localparam int unsigned MAX_1 = (MAX_0 > E_PULSE_CYC) ? MAX_0 : E_PULSE_CYC;
  localparam int unsigned MAX_2 = (MAX_1 > CMD_WAIT_CYC) ? MAX_1 : CMD_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_2 > CLR_WAIT_CYC) ? MAX_2 : CLR_WAIT_CYC;
  localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned INIT_LAST = 5;

  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EPULS_LD = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMDW_LD  = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLRW_LD  = CNT_W'(CLR_WAIT_CYC - 1);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_EHIGH = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_IDLE  = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_init_done;
  logic             w_init_done_nxt;
  logic             w_take;
  logic             w_have_req;
  logic             w_long;
  logic             w_head_rs;
  logic [7:0]       w_head_data;
  logic             w_ready_nxt;
  logic             w_busy_nxt;

  logic             r_req_rs;
  logic [7:0]       r_req_data;
  logic             r_lcd_rs;
  logic [7:0]       r_lcd_db;
  logic             r_lcd_e;
  logic             r_busy;
  logic             r_ready;

  // Fixed HD44780 8-bit init sequence
  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      3'd5:             init_rom = 8'h06;
      default:          init_rom = 8'h00;
    endcase
  endfunction

  // Clear and return-home need the long execution wait
  assign w_long = !r_lcd_rs && (r_lcd_db[7:2] == 6'd0) && (r_lcd_db[1:0] != 2'd0);

`ifdef CLCD_REQ_FIFO_EN
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned FCNT_W = 3;

  logic [8:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_nxt;
  logic              w_push;

  assign w_push      = req.req_valid && r_ready;
  assign w_have_req  = r_init_done && (r_fcnt != '0);
  assign w_head_rs   = r_fifo[r_rd_ptr][8];
  assign w_head_data = r_fifo[r_rd_ptr][7:0];
  assign w_fcnt_nxt  = r_fcnt + FCNT_W'(w_push) - FCNT_W'(w_take);
  assign w_ready_nxt = (w_fcnt_nxt != FCNT_W'(FIFO_DEPTH));
  assign w_busy_nxt  = (w_state_nxt != S_IDLE) || (w_fcnt_nxt != '0);

  // FIFO storage, written on push
  always_ff @(posedge ACLK) begin
    if (w_push) r_fifo[r_wr_ptr] <= {req.req_rs, req.req_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_take) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_fcnt <= w_fcnt_nxt;
    end
  end
`else
  assign w_have_req  = req.req_valid && r_ready;
  assign w_head_rs   = req.req_rs;
  assign w_head_data = req.req_data;
  assign w_ready_nxt = (w_state_nxt == S_IDLE) && w_init_done_nxt;
  assign w_busy_nxt  = (w_state_nxt != S_IDLE);
`endif

  // State, counter, init index and init_done registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= S_PWRUP;
      r_cnt       <= PWRUP_LD;
      r_idx       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Next-state logic; the down-counter is reloaded on every state entry
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_init_done_nxt = r_init_done;
    w_take          = 1'b0;
    case (r_state)
      S_PWRUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_LOAD: begin
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = SETUP_LD;
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_EHIGH;
          w_cnt_nxt   = EPULS_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_EHIGH: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = SETUP_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_long ? CLRW_LD : CMDW_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          if (!r_init_done && (r_idx != IDX_W'(INIT_LAST))) begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_LOAD;
          end else begin
            w_init_done_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (w_have_req) begin
          w_take      = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_PWRUP;
        w_cnt_nxt   = PWRUP_LD;
      end
    endcase
  end

  // Capture the accepted request byte
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_req_rs   <= 1'b0;
      r_req_data <= 8'h00;
    end else if (w_take) begin
      r_req_rs   <= w_head_rs;
      r_req_data <= w_head_data;
    end
  end

  // Registered LCD pins and status; RS/DB only change on leaving LOAD
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_lcd_rs <= 1'b0;
      r_lcd_db <= 8'h00;
      r_lcd_e  <= 1'b0;
      r_busy   <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_lcd_rs <= r_init_done && r_req_rs;
        r_lcd_db <= r_init_done ? r_req_data : init_rom(r_idx);
      end
      r_lcd_e <= (w_state_nxt == S_EHIGH);
      r_busy  <= w_busy_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign req.req_ready = r_ready;
  assign init_done     = r_init_done;
  assign busy          = r_busy;
  assign lcd_rs        = r_lcd_rs;
  assign lcd_rw        = 1'b0;
  assign lcd_e         = r_lcd_e;
  assign lcd_db        = r_lcd_db;

endmodule
